// File: rtl/wd_pkg.sv
// Shared types and the trip-cause priority helper for the multi-channel watchdog.
package wd_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_TIMEOUT = 2'd1,
        CAUSE_EARLY   = 2'd2,
        CAUSE_FORCED  = 2'd3
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WARN    = 2'd2,
        ST_TRIPPED = 2'd3
    } state_t;

    // A forced trip outranks an early kick, which outranks a plain timeout.
    function automatic cause_t pick_cause(input logic forced, input logic early, input logic timeout);
        cause_t c;
        if (forced) begin
            c = CAUSE_FORCED;
        end else if (early) begin
            c = CAUSE_EARLY;
        end else if (timeout) begin
            c = CAUSE_TIMEOUT;
        end else begin
            c = CAUSE_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/wd_channel.sv
// One watchdog channel: heartbeat edge detect, cycle counter, state machine,
// sticky trip flag and cause code.
module wd_channel
    import wd_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000,
    parameter int WARN_AT = 750,
    parameter int WIN_MIN = 0
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   enable,
    input  logic   heartbeat,
    input  logic   clear,
    input  logic   force_reset,
    output logic   warning,
    output logic   triggered,
    output cause_t cause
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WARN_CNT = CNT_W'(WARN_AT);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hb_q, hb_d;
    logic             warning_q, warning_d;
    logic             triggered_q, triggered_d;
    cause_t           cause_q, cause_d;

    logic             hb_edge, in_window, early_hit, timeout_hit;
    cause_t           trip_cause;

    if (WIN_MIN > 0) begin : g_window
        localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_MIN);
        assign in_window = (cnt_q < WIN_CNT);
    end else begin : g_no_window
        assign in_window = 1'b0;
    end

    // Next-state, counter and trip bookkeeping; clear beats a simultaneous trip.
    always_comb begin
        hb_d        = heartbeat;
        hb_edge     = heartbeat & ~hb_q;
        early_hit   = hb_edge & in_window;
        timeout_hit = ~hb_edge & (cnt_q == LAST_CNT);
        trip_cause  = pick_cause(force_reset, early_hit, timeout_hit);
        state_d     = state_q;
        cnt_d       = cnt_q;
        triggered_d = triggered_q;
        cause_d     = cause_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = ZERO_CNT;
                if (enable) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED, ST_WARN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO_CNT;
                end else if (trip_cause != CAUSE_NONE) begin
                    cnt_d = ZERO_CNT;
                    if (clear) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_TRIPPED;
                        triggered_d = 1'b1;
                        cause_d     = trip_cause;
                    end
                end else if (hb_edge) begin
                    state_d = ST_ARMED;
                    cnt_d   = ZERO_CNT;
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                    if (cnt_d >= WARN_CNT) begin
                        state_d = ST_WARN;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_TRIPPED: begin
                cnt_d = ZERO_CNT;
                if (clear) begin
                    state_d     = ST_IDLE;
                    triggered_d = 1'b0;
                    cause_d     = CAUSE_NONE;
                end else begin
                    state_d = ST_TRIPPED;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = ZERO_CNT;
                triggered_d = 1'b0;
                cause_d     = CAUSE_NONE;
            end
        endcase
        warning_d = (state_d == ST_WARN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= ZERO_CNT;
            hb_q        <= 1'b0;
            warning_q   <= 1'b0;
            triggered_q <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hb_q        <= hb_d;
            warning_q   <= warning_d;
            triggered_q <= triggered_d;
            cause_q     <= cause_d;
        end
    end

    assign warning   = warning_q;
    assign triggered = triggered_q;
    assign cause     = cause_q;

endmodule

// File: rtl/multi_channel_watchdog.sv
// N-channel watchdog supervisor: per-channel supervisors plus the aggregated
// trip level and single-cycle trip pulse for the reset controller.
module multi_channel_watchdog
    import wd_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000,
    parameter int WARN_AT = 750,
    parameter int WIN_MIN = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_CH-1:0]   enable,
    input  logic [N_CH-1:0]   heartbeat,
    input  logic [N_CH-1:0]   clear,
    input  logic              force_reset,
    output logic [N_CH-1:0]   warning,
    output logic [N_CH-1:0]   triggered,
    output logic [2*N_CH-1:0] cause,
    output logic              any_trip,
    output logic              trip_pulse
);

    if (N_CH < 1) begin : g_bad_nch
        $error("multi_channel_watchdog: N_CH must be at least 1");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("multi_channel_watchdog: TIMEOUT must be at least 2");
    end
    if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_width
        $error("multi_channel_watchdog: TIMEOUT does not fit in CNT_W bits");
    end
    if ((WARN_AT <= 0) || (WARN_AT >= TIMEOUT)) begin : g_bad_warn
        $error("multi_channel_watchdog: WARN_AT must lie strictly between 0 and TIMEOUT");
    end
    if ((WIN_MIN < 0) || (WIN_MIN >= WARN_AT)) begin : g_bad_win
        $error("multi_channel_watchdog: WIN_MIN must be non-negative and below WARN_AT");
    end

    cause_t          ch_cause [N_CH];
    logic [N_CH-1:0] trig_prev_q, trig_prev_d;
    logic            trip_pulse_q, trip_pulse_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        wd_channel #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT),
            .WARN_AT (WARN_AT),
            .WIN_MIN (WIN_MIN)
        ) u_channel (
            .clk         (clk),
            .rstn        (rstn),
            .enable      (enable[i]),
            .heartbeat   (heartbeat[i]),
            .clear       (clear[i]),
            .force_reset (force_reset),
            .warning     (warning[i]),
            .triggered   (triggered[i]),
            .cause       (ch_cause[i])
        );
        assign cause[2*i +: 2] = ch_cause[i];
    end

    // Any fresh 0->1 on a trip flag yields one pulse, however many channels rose.
    always_comb begin
        trig_prev_d  = triggered;
        trip_pulse_d = |(triggered & ~trig_prev_q);
    end

    // Trip edge history and pulse register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_prev_q  <= {N_CH{1'b0}};
            trip_pulse_q <= 1'b0;
        end else begin
            trig_prev_q  <= trig_prev_d;
            trip_pulse_q <= trip_pulse_d;
        end
    end

    assign any_trip   = |triggered;
    assign trip_pulse = trip_pulse_q;

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares them after every clock edge.
module tb_multi_channel_watchdog;

    localparam int NC      = 4;
    localparam int TIMEOUT = 8;
    localparam int WARN_AT = 6;
    localparam int WIN_MIN = 2;

    typedef struct packed {
        logic [3:0] warn;
        logic [3:0] trig;
        logic [7:0] cause;
        logic       any;
        logic       pulse;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NC-1:0] enable, heartbeat, clear;
    logic          force_reset;
    logic [NC-1:0] warning, triggered;
    logic [2*NC-1:0] cause;
    logic          any_trip, trip_pulse;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_cycle = 0;
    exp_t exp_q[$];

    // Reference model: mode 0 off, 1 running, 2 tripped; age = cycles since arm/kick.
    int m_mode  [NC];
    int m_age   [NC];
    int m_cause [NC];
    bit m_hb_prev [NC];
    bit m_pulse_next;

    multi_channel_watchdog #(
        .N_CH    (NC),
        .CNT_W   (16),
        .TIMEOUT (TIMEOUT),
        .WARN_AT (WARN_AT),
        .WIN_MIN (WIN_MIN)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .heartbeat   (heartbeat),
        .clear       (clear),
        .force_reset (force_reset),
        .warning     (warning),
        .triggered   (triggered),
        .cause       (cause),
        .any_trip    (any_trip),
        .trip_pulse  (trip_pulse)
    );

    always #5 clk = ~clk;

    function automatic exp_t dut_obs();
        exp_t o;
        o.warn  = warning;
        o.trig  = triggered;
        o.cause = cause;
        o.any   = any_trip;
        o.pulse = trip_pulse;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NC; ch++) begin
            m_mode[ch] = 0; m_age[ch] = 0; m_cause[ch] = 0; m_hb_prev[ch] = 1'b0;
        end
        m_pulse_next = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] en, input logic [3:0] hb, input logic [3:0] clr,
                              input logic frc, output exp_t e);
        bit rose, kick;
        int c;
        rose = 1'b0;
        for (int ch = 0; ch < NC; ch++) begin
            kick = hb[ch] && !m_hb_prev[ch];
            m_hb_prev[ch] = hb[ch];
            if (m_mode[ch] == 0) begin
                if (en[ch]) begin m_mode[ch] = 1; m_age[ch] = 0; end
            end else if (m_mode[ch] == 2) begin
                if (clr[ch]) begin m_mode[ch] = 0; m_cause[ch] = 0; end
            end else if (!en[ch]) begin
                m_mode[ch] = 0; m_age[ch] = 0;
            end else begin
                if (frc) c = 3;
                else if (kick && m_age[ch] < WIN_MIN) c = 2;
                else if (!kick && m_age[ch] == TIMEOUT - 1) c = 1;
                else c = 0;
                if (c != 0 && clr[ch]) begin
                    m_mode[ch] = 0; m_age[ch] = 0;
                end else if (c != 0) begin
                    m_mode[ch] = 2; m_cause[ch] = c; m_age[ch] = 0; rose = 1'b1;
                end else if (kick) begin
                    m_age[ch] = 0;
                end else begin
                    m_age[ch]++;
                end
            end
        end
        e.pulse = m_pulse_next;
        m_pulse_next = rose;
        for (int ch = 0; ch < NC; ch++) begin
            e.warn[ch] = (m_mode[ch] == 1) && (m_age[ch] >= WARN_AT);
            e.trig[ch] = (m_mode[ch] == 2);
            e.cause[2*ch +: 2] = 2'(m_cause[ch]);
        end
        e.any = |e.trig;
    endtask

    task automatic step(input logic [3:0] en, input logic [3:0] hb, input logic [3:0] clr, input logic frc);
        exp_t e;
        @(negedge clk);
        enable = en; heartbeat = hb; clear = clr; force_reset = frc;
        model_step(en, hb, clr, frc, e);
        exp_q.push_back(e);
    endtask

    task automatic wait_obs();
        @(posedge clk);
        #3;
    endtask

    // Monitor: compare the DUT against the oldest pending expectation after each edge.
    initial begin : monitor
        exp_t want, got;
        forever begin
            @(posedge clk);
            #2;
            n_cycle++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = dut_obs();
                n_total++;
                if (got === want) n_pass++;
                else $display("FAIL scoreboard cycle %0d: got %h expected %h", n_cycle, got, want);
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin : driver
        int p;
        logic [3:0] en_r, hb_r, clr_r;
        logic frc_r;
        rstn = 1'b0; enable = 4'h0; heartbeat = 4'h0; clear = 4'h0; force_reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_low", 32'(dut_obs()), 32'd0);
        rstn = 1'b1;
        #1 check("reset_state", 32'(dut_obs()), 32'd0);

        // Timeout on channel 0: warning at edge 7, trip at edge 9, pulse at edge 10 only.
        for (int k = 1; k <= 11; k++) begin
            step(4'b0001, 4'h0, 4'h0, 1'b0);
            wait_obs();
            check("t1_warning0", 32'(warning[0]), 32'(k >= 7 && k < 9));
            check("t1_triggered0", 32'(triggered[0]), 32'(k >= 9));
            check("t1_pulse", 32'(trip_pulse), 32'(k == 10));
        end
        wait_obs();
        check("t1_cause0", 32'(cause[1:0]), 32'd1);

        // Channel 1 kicked every 5 cycles never warns or trips.
        step(4'h0, 4'h0, 4'hF, 1'b0);
        p = 0;
        for (int c = 0; c < 100; c++) begin
            step(4'b0010, (c % 5 == 4) ? 4'b0010 : 4'b0000, 4'h0, 1'b0);
            wait_obs();
            p += int'(warning[1]) + int'(triggered[1]);
        end
        check("t2_kicked_quiet", 32'(p), 32'd0);

        // Channel 2: kick at count 1 is early; kick at count 7 is accepted.
        step(4'h0, 4'h0, 4'hF, 1'b0);
        step(4'b0100, 4'h0, 4'h0, 1'b0);
        step(4'b0100, 4'h0, 4'h0, 1'b0);
        step(4'b0100, 4'b0100, 4'h0, 1'b0);
        wait_obs();
        check("t3_early_trig", 32'(triggered[2]), 32'd1);
        check("t3_early_cause", 32'(cause[5:4]), 32'd2);
        step(4'b0100, 4'h0, 4'b0100, 1'b0);
        step(4'b0100, 4'h0, 4'h0, 1'b0);
        for (int j = 1; j <= 7; j++) step(4'b0100, 4'h0, 4'h0, 1'b0);
        wait_obs();
        check("t3_warn_before_kick", 32'(warning[2]), 32'd1);
        step(4'b0100, 4'b0100, 4'h0, 1'b0);
        wait_obs();
        check("t3_late_kick_trig", 32'(triggered[2]), 32'd0);
        check("t3_late_kick_warn", 32'(warning[2]), 32'd0);

        // force_reset with channel 3 already timed out.
        step(4'h0, 4'h0, 4'hF, 1'b0);
        for (int j = 0; j < 9; j++) step(4'b1000, 4'h0, 4'h0, 1'b0);
        step(4'hF, 4'h0, 4'h0, 1'b0);
        step(4'hF, 4'h0, 4'h0, 1'b0);
        step(4'hF, 4'h0, 4'h0, 1'b1);
        wait_obs();
        check("t4_force_cause", 32'(cause), 32'h7F);
        check("t4_force_trig", 32'(triggered), 32'hF);
        p = int'(trip_pulse);
        for (int j = 0; j < 2; j++) begin
            step(4'hF, 4'h0, 4'h0, 1'b0);
            wait_obs();
            p += int'(trip_pulse);
        end
        check("t4_single_pulse", 32'(p), 32'd1);

        // clear coinciding with the timeout condition wins.
        step(4'h0, 4'h0, 4'hF, 1'b0);
        for (int j = 0; j < 8; j++) step(4'b0001, 4'h0, 4'h0, 1'b0);
        step(4'b0001, 4'h0, 4'b0001, 1'b0);
        wait_obs();
        check("t5_clear_wins", 32'(triggered[0]), 32'd0);
        step(4'b0001, 4'h0, 4'h0, 1'b0);
        wait_obs();
        check("t5_no_pulse", 32'(trip_pulse), 32'd0);

        // Asynchronous reset with channel 0 warning and channel 1 tripped.
        step(4'h0, 4'h0, 4'hF, 1'b0);
        step(4'b0011, 4'h0, 4'h0, 1'b0);
        step(4'b0011, 4'b0010, 4'h0, 1'b0);
        for (int j = 2; j <= 6; j++) step(4'b0011, 4'h0, 4'h0, 1'b0);
        wait_obs();
        check("t6_pre_warn0", 32'(warning[0]), 32'd1);
        check("t6_pre_trig1", 32'(triggered[1]), 32'd1);
        #1 rstn = 1'b0;
        #1 check("t6_async_reset", 32'(dut_obs()), 32'd0);
        enable = 4'h0; heartbeat = 4'h0; clear = 4'h0; force_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        for (int k = 1; k <= 9; k++) begin
            step(4'b0001, 4'h0, 4'h0, 1'b0);
            wait_obs();
            check("t6_post_reset_trip", 32'(triggered[0]), 32'(k == 9));
        end

        // Randomised traffic against the reference model.
        en_r = 4'hF;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 31) == 0) en_r = 4'($urandom);
            hb_r  = 4'($urandom & $urandom & $urandom);
            clr_r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            frc_r = ($urandom_range(0, 63) == 0);
            step(en_r, hb_r, clr_r, frc_r);
        end

        repeat (3) @(posedge clk);
        #4;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
